// File: rtl/iir_cfg_ctrl.sv
// iir_cfg_ctrl: sample-rate strobe, sample latch, shadow/active coefficient banks
// with sample-aligned atomic swap, and fixed-latency capture of the IIR datapath output.
module iir_cfg_ctrl #(
  parameter int N_BITS = 32,
  parameter int DIV_W  = 16,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [1:0]        cfg_addr_i,
  input  logic [N_BITS-1:0] cfg_data_i,
  input  logic              commit_i,
  input  logic [N_BITS-1:0] x_i,
  input  logic [N_BITS-1:0] y_i,
  output logic [N_BITS-1:0] x_o,
  output logic [N_BITS-1:0] b0_o,
  output logic [N_BITS-1:0] b1_o,
  output logic [N_BITS-1:0] a_o,
  output logic [N_BITS-1:0] offset_o,
  output logic              sample_en_o,
  output logic              swap_o,
  output logic [N_BITS-1:0] y_o,
  output logic              y_valid_o,
  output logic              pending_o
);
  typedef enum logic [1:0] {IDLE, RUN, ARMED} state_t;
  state_t            state, state_nxt;
  logic [DIV_W-1:0]  cnt;
  logic [N_BITS-1:0] shadow [4];
  logic [N_BITS-1:0] shadow_nxt [4];
  logic [LAT:0]      pipe;
  logic              tick, swap, wr;
  assign tick        = (state != IDLE) && (cnt >= div_i);
  assign sample_en_o = tick;
  assign cfg_ready_o = state != ARMED;
  assign pending_o   = state == ARMED;
  assign wr          = cfg_valid_i && cfg_ready_o;
  assign swap        = (state == IDLE && commit_i) || (state == ARMED && (tick || !enable_i));
  always_comb begin
    state_nxt = !enable_i ? IDLE :
                state == IDLE ? RUN :
                state == RUN && commit_i ? ARMED :
                state == ARMED && tick ? RUN : state;
    // The active bank loads from shadow_nxt so a write in the commit cycle is included
    for (int i = 0; i < 4; i++)
      shadow_nxt[i] = (wr && cfg_addr_i == 2'(i)) ? cfg_data_i : shadow[i];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shadow    <= '{default: '0};
      b0_o      <= '0;
      b1_o      <= '0;
      a_o       <= '0;
      offset_o  <= '0;
      x_o       <= '0;
      swap_o    <= 1'b0;
      pipe      <= '0;
      y_o       <= '0;
      y_valid_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= (state == IDLE || state_nxt == IDLE || tick) ? '0 : cnt + 1'b1;
      shadow    <= shadow_nxt;
      swap_o    <= swap;
      pipe      <= {pipe[LAT-1:0], tick};
      y_valid_o <= pipe[LAT];
      if (tick) x_o <= x_i;
      if (pipe[LAT]) y_o <= y_i;
      if (swap) begin
        b0_o     <= shadow_nxt[0];
        b1_o     <= shadow_nxt[1];
        a_o      <= shadow_nxt[2];
        offset_o <= shadow_nxt[3];
      end
    end
endmodule

// File: tb/tb_iir_cfg_ctrl.sv
// tb_iir_cfg_ctrl: randomized and directed stimulus for iir_cfg_ctrl; a behavioural model
// predicts ticks, samples, swaps and captures, and a monitor scores the DUT against them.
module tb_iir_cfg_ctrl;
  localparam int N = 32, DW = 16, LAT = 1, W = 4 * N;
  logic clk = 0, reset = 1;
  logic enable_i = 0, cfg_valid_i = 0, commit_i = 0;
  logic [DW-1:0] div_i = '0;
  logic [1:0] cfg_addr_i = '0;
  logic [N-1:0] cfg_data_i = '0, x_i = '0, y_i = '0;
  logic cfg_ready_o, sample_en_o, swap_o, y_valid_o, pending_o;
  logic [N-1:0] x_o, b0_o, b1_o, a_o, offset_o, y_o;

  always #5 clk = ~clk;

  iir_cfg_ctrl #(.N_BITS(N), .DIV_W(DW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .enable_i(enable_i), .div_i(div_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_addr_i(cfg_addr_i),
    .cfg_data_i(cfg_data_i), .commit_i(commit_i), .x_i(x_i), .y_i(y_i), .x_o(x_o),
    .b0_o(b0_o), .b1_o(b1_o), .a_o(a_o), .offset_o(offset_o), .sample_en_o(sample_en_o),
    .swap_o(swap_o), .y_o(y_o), .y_valid_o(y_valid_o), .pending_o(pending_o)
  );

  typedef struct { int c; logic [W-1:0] v; } ev_t;
  int q_tick[$];
  logic [N-1:0] q_x[$];
  ev_t q_y[$], q_sw[$];
  ev_t mon_e;
  int errors = 0, checks = 0, cyc = 0;
  bit go = 0, px = 0;
  // Reference model: register-level view of what the spec promises, not of how the RTL is built
  logic [N-1:0] shadow [4], active [4];
  bit run = 0, armed = 0, last_tick = 0;
  int phase = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] yfun(input int c);
    return N'(c) * 32'h9E3779B1 ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string n);
    checks++;
    errors++;
    $display("FAIL %s: DUT event with nothing expected (cycle %0d)", n, cyc);
  endtask

  task automatic model_clear();
    q_tick.delete(); q_x.delete(); q_y.delete(); q_sw.delete();
    run = 0; armed = 0; phase = 0; last_tick = 0;
    for (int i = 0; i < 4; i++) begin shadow[i] = '0; active[i] = '0; end
  endtask

  task automatic step(input int en, input int dv, input int cv, input int ca,
                      input logic [N-1:0] cd, input int cm, input logic [N-1:0] x);
    bit tk, sw;
    @(negedge clk);
    enable_i = (en != 0); div_i = DW'(dv); cfg_valid_i = (cv != 0); cfg_addr_i = 2'(ca);
    cfg_data_i = cd; commit_i = (cm != 0); x_i = x; y_i = yfun(cyc);
    #1;
    chk("pending", W'(pending_o), W'(armed));
    chk("cfg_ready", W'(cfg_ready_o), W'(!armed));
    chk("coefs", {b0_o, b1_o, a_o, offset_o}, {active[0], active[1], active[2], active[3]});
    tk = run && phase >= dv;
    if (tk) begin
      q_tick.push_back(cyc);
      q_x.push_back(x);
      q_y.push_back('{cyc + 2 + LAT, W'(yfun(cyc + 1 + LAT))});
    end
    if (cv != 0 && !armed) shadow[ca] = cd;
    sw = (!run && cm != 0) || (armed && (tk || en == 0));
    if (sw) begin
      for (int i = 0; i < 4; i++) active[i] = shadow[i];
      q_sw.push_back('{cyc + 1, {shadow[0], shadow[1], shadow[2], shadow[3]}});
    end
    if (en == 0) begin run = 0; armed = 0; phase = 0; end
    else if (!run) begin run = 1; phase = 0; end
    else begin
      armed = armed ? !tk : (cm != 0);
      phase = tk ? 0 : phase + 1;
    end
    last_tick = tk;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #4;
    reset = 0;
    enable_i = 0; cfg_valid_i = 0; commit_i = 0;
    #1;
    chk("reset_coefs", {b0_o, b1_o, a_o, offset_o}, '0);
    chk("reset_xy", W'({x_o, y_o}), '0);
    chk("reset_flags", W'({sample_en_o, swap_o, y_valid_o, pending_o, cfg_ready_o}), W'(5'b00001));
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  always begin
    @(negedge clk);
    #2;
    if (!reset || !go) px = 0;
    else begin
      if (px) begin
        if (q_x.size() == 0) unexp("x_o");
        else chk("x_o", W'(x_o), W'(q_x.pop_front()));
      end
      px = sample_en_o;
      if (sample_en_o) begin
        if (q_tick.size() == 0) unexp("sample_en");
        else chk("tick_cycle", W'(cyc), W'(q_tick.pop_front()));
      end
      if (y_valid_o) begin
        if (q_y.size() == 0) unexp("y_valid");
        else begin
          mon_e = q_y.pop_front();
          chk("y_cycle", W'(cyc), W'(mon_e.c));
          chk("y_o", W'(y_o), mon_e.v);
        end
      end
      if (swap_o) begin
        if (q_sw.size() == 0) unexp("swap");
        else begin
          mon_e = q_sw.pop_front();
          chk("swap_cycle", W'(cyc), W'(mon_e.c));
          chk("swap_bank", {b0_o, b1_o, a_o, offset_o}, mon_e.v);
        end
      end
    end
  end

  initial begin
    model_clear();
    do_reset();
    go = 1;
    idle(20);
    step(0, 0, 1, 0, 32'h00004AFA, 0, 0);
    step(0, 0, 1, 1, 32'h00004AFA, 0, 0);
    step(0, 0, 1, 2, 32'hFFFF95F7, 0, 0);
    step(0, 0, 1, 3, 32'h00000000, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(2);
    for (int i = 1; i <= 16; i++) step(1, 3, 0, 0, 0, 0, i);
    step(1, 3, 1, 2, 32'h00001000, 0, 17);
    for (int i = 0; i < 8 && !last_tick; i++) step(1, 3, 0, 0, 0, 0, 18 + i);
    step(1, 3, 0, 0, 0, 1, 30);
    for (int i = 0; i < 6; i++) step(1, 3, 1, 0, 32'hDEAD0000 + i, 0, 31 + i);
    step(1, 3, 1, 3, 32'h00000010, 1, 40);
    step(1, 3, 0, 0, 0, 1, 41);
    for (int i = 0; i < 8; i++) step(1, 3, 0, 0, 0, 0, 42 + i);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 60 + i);
    idle(1);
    for (int i = 0; i < 20 && phase != 5; i++) step(1, 9, 0, 0, 0, 0, 70 + i);
    step(1, 2, 0, 0, 0, 0, 99);
    step(1, 2, 0, 0, 0, 0, 100);
    step(1, 3, 1, 1, 32'h00000077, 1, 101);
    step(0, 3, 0, 0, 0, 0, 102);
    idle(4);
    for (int i = 0; i < 400; i++)
      step(int'($urandom_range(0, 19) != 0), int'($urandom_range(0, 5)),
           int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)), $urandom,
           int'($urandom_range(0, 15) == 0), $urandom);
    step(1, 4, 0, 0, 0, 0, 200);
    for (int i = 0; i < 10 && !last_tick; i++) step(1, 4, 0, 0, 0, 0, 201 + i);
    do_reset();
    idle(10);
    idle(8);
    chk("queues_drained", W'(q_tick.size() + q_x.size() + q_y.size() + q_sw.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
